// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: widths, FSM encoding, MixColumns coefficients
// and the GF(2^8) arithmetic used by the column logic.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int COL_W   = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Row-0 coefficients; element j multiplies byte a[j]. Other rows rotate.
    localparam logic [3:0][7:0] ENC_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
    localparam logic [3:0][7:0] DEC_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = b;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (byte 0 at LSBs).
module mix_column_word
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    input  logic             enc_dec,
    output logic [COL_W-1:0] col_out
);

    logic [3:0][7:0] a;
    logic [3:0][7:0] coef;

    assign a    = col_in;
    assign coef = enc_dec ? ENC_COEF : DEC_COEF;

    // Output byte r takes coefficient j against input byte (r+j) mod 4.
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                col_out[r*8 +: 8] = col_out[r*8 +: 8] ^ gf_mul(a[2'(r + j)], coef[j]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns stage: COLS_PER_CYCLE columns per clock, result held
// on data_out until the consumer takes it.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] data_in,
    input  logic               enc_dec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] data_out
);

    localparam int         N_STEPS   = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]         state_q;
    logic [1:0]         cnt_q;
    logic               dir_q;
    logic [STATE_W-1:0] work_q;
    logic [STATE_W-1:0] res_q;
    logic [STATE_W-1:0] res_next;
    logic               out_valid_q;
    logic [STATE_W-1:0] data_out_q;

    logic [1:0]       col_idx [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

    logic accept;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds data stable until then. A waiting DONE result
    // may be replaced on the same edge the consumer takes it.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

    always_comb begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            col_idx[i] = 2'(int'(cnt_q) * COLS_PER_CYCLE + i);
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_in[g] = work_q[{col_idx[g], 5'b0} +: COL_W];

        mix_column_word u_col (
            .col_in  (col_in[g]),
            .enc_dec (dir_q),
            .col_out (col_out[g])
        );
    end

    always_comb begin
        res_next = res_q;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            res_next[{col_idx[i], 5'b0} +: COL_W] = col_out[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            dir_q       <= 1'b1;
            work_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else if (accept) begin
            work_q      <= data_in;
            dir_q       <= enc_dec;
            cnt_q       <= 2'd0;
            state_q     <= BUSY;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUSY: begin
                    res_q <= res_next;
                    if (cnt_q == LAST_STEP) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        data_out_q  <= res_next;
                        cnt_q       <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                IDLE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per clock)
// checked against a matrix-level GF(2^8) reference model.
module tb_mix_columns_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         enc_dec   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] data_in   [3];
    logic [127:0] data_out  [3];

    int checks   = 0;
    int failures = 0;
    int nsteps [3] = '{4, 2, 1};

    mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .data_in(data_in[0]), .enc_dec(enc_dec[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .data_out(data_out[0]));
    mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .data_in(data_in[1]), .enc_dec(enc_dec[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .data_out(data_out[1]));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .data_in(data_in[2]), .enc_dec(enc_dec[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .data_out(data_out[2]));

    // Reference model: shift-and-add GF(2^8) product and an explicit matrix.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 32'h100) != 0) x = x ^ 32'h11b;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic enc);
        logic [7:0] base [4];
        logic [7:0] m [4][4];
        logic [7:0] acc;
        logic [127:0] r;
        if (enc) base = '{8'h02, 8'h03, 8'h01, 8'h01};
        else     base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int row = 0; row < 4; row++)
            for (int k = 0; k < 4; k++)
                m[row][k] = base[(k - row + 4) % 4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ ref_mul(m[row][k], s[32*c + 8*k +: 8]);
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain(input int k);
        @(negedge clk); out_ready[k] = 1'b1;
        @(posedge clk); #1; out_ready[k] = 1'b0;
    endtask

    task automatic run(input int k, input logic [127:0] din, input logic enc,
                       output logic [127:0] dout, output int lat);
        @(negedge clk);
        in_valid[k] = 1'b1; data_in[k] = din; enc_dec[k] = enc;
        #1 chk("in_ready_idle", 128'(in_ready[k]), 128'(1));
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        wait_out(k, lat);
        dout = data_out[k];
        drain(k);
    endtask

    logic [127:0] vec_in  = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
    logic [127:0] vec_out = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};

    initial begin
        logic [127:0] a, b, got, held;
        int lat;

        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; enc_dec[k] = 1'b1; out_ready[k] = 1'b0; data_in[k] = '0;
        end
        rst_n = 1'b0;
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready", 128'(in_ready[k]), 128'(1));
            chk("reset_out_valid", 128'(out_valid[k]), 128'(0));
            chk("reset_data_out", data_out[k], 128'h0);
        end
        @(negedge clk); rst_n = 1'b1;

        // Directed vector, encrypt then inverse.
        run(0, vec_in, 1'b1, got, lat);
        chk("vec_enc_data", got, vec_out);
        chk("vec_enc_latency", 128'(lat), 128'(4));
        run(0, vec_out, 1'b0, got, lat);
        chk("vec_dec_data", got, vec_in);

        // Round trip on all three widths.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 4; t++) begin
                a = (t == 0) ? 128'h63cab7040953d051cd60e0e7ba70e18c
                             : {$urandom, $urandom, $urandom, $urandom};
                run(k, a, 1'b1, got, lat);
                chk("rt_enc_model", got, ref_mix(a, 1'b1));
                chk("rt_enc_latency", 128'(lat), 128'(nsteps[k]));
                run(k, got, 1'b0, b, lat);
                chk("rt_dec_roundtrip", b, a);
                chk("rt_dec_latency", 128'(lat), 128'(nsteps[k]));
            end
        end

        // Backpressure with a pending input, then simultaneous handshakes.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid[1] = 1'b1; data_in[1] = a; enc_dec[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        wait_out(1, lat);
        chk("bp_first_latency", 128'(lat), 128'(2));
        held = data_out[1];
        chk("bp_first_data", held, ref_mix(a, 1'b1));
        @(negedge clk);
        in_valid[1] = 1'b1; data_in[1] = b; enc_dec[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_stall_data", data_out[1], held);
            chk("bp_stall_in_ready", 128'(in_ready[1]), 128'(0));
            chk("bp_stall_out_valid", 128'(out_valid[1]), 128'(1));
        end
        @(negedge clk);
        out_ready[1] = 1'b1;
        #1 chk("bp_both_in_ready", 128'(in_ready[1]), 128'(1));
        @(posedge clk); #1;
        in_valid[1] = 1'b0; out_ready[1] = 1'b0;
        chk("bp_taken_out_valid", 128'(out_valid[1]), 128'(0));
        chk("bp_taken_data_hold", data_out[1], held);
        wait_out(1, lat);
        chk("bp_second_latency", 128'(lat), 128'(2));
        chk("bp_second_data", data_out[1], ref_mix(b, 1'b0));
        drain(1);

        // Direction toggling while busy must not disturb the result.
        a = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid[0] = 1'b1; data_in[0] = a; enc_dec[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 20) begin
            @(negedge clk); enc_dec[0] = ~enc_dec[0];
            @(posedge clk); #1;
            lat++;
        end
        chk("dir_iso_latency", 128'(lat), 128'(4));
        chk("dir_iso_data", data_out[0], ref_mix(a, 1'b1));
        drain(0);

        // Reset while busy, then a fresh all-zero state.
        a = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid[0] = 1'b1; data_in[0] = a; enc_dec[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 128'(out_valid[0]), 128'(0));
        chk("rst_mid_data_out", data_out[0], 128'h0);
        chk("rst_mid_in_ready", 128'(in_ready[0]), 128'(1));
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_no_spurious_valid", 128'(out_valid[0]), 128'(0));
        end
        run(0, 128'h0, 1'b1, got, lat);
        chk("rst_zero_data", got, 128'h0);
        chk("rst_zero_latency", 128'(lat), 128'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative AES MixColumns / InvMixColumns stage, directly downstream of shift_rows in the round datapath.
- Accepts a 128-bit state plus a direction bit over a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock using shared GF(2^8) column logic, then holds the 128-bit result until the consumer takes it.
- Trades latency for area versus a fully parallel four-column implementation.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- Derived constant: N_STEPS = 4 / COLS_PER_CYCLE.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_in and enc_dec are valid.
- in_ready  output  1  block can accept a new state.
- data_in  input  128  state. Column c = bits [32c+31:32c]; row r of column c = bits [32c+8r+7:32c+8r]. Byte 0 sits at the LSBs, the same packing shift_rows uses.
- enc_dec  input  1  1 = MixColumns (encrypt), 0 = InvMixColumns (decrypt). Sampled on accept.
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  consumer takes data_out.
- data_out  output  128  transformed state, same packing as data_in.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, step counter = 0, out_valid = 0, data_out = 0.
  - Latched direction = 1, working register = 0.
  - in_ready = 1 whenever state is IDLE, including during reset.
- Accept: a transfer occurs on a rising edge with in_valid & in_ready.
  - On that edge: data_in goes into the working register, enc_dec is latched, the counter clears, and state goes to BUSY.
- BUSY, one step per clock:
  - Step s transforms columns s*COLS_PER_CYCLE .. s*COLS_PER_CYCLE+COLS_PER_CYCLE-1 of the working register.
  - Results are written into the same bit positions of the result register.
  - Untouched columns keep their value.
- Completion: on the edge that writes step N_STEPS-1, out_valid goes to 1 and state goes to DONE.
  - Latency from the accept edge to out_valid high is exactly N_STEPS clocks: 4, 2 or 1.
  - data_out updates only on that completion edge. Partial results are never visible on data_out.
- DONE:
  - data_out and out_valid stay stable until out_ready is sampled high.
  - out_valid & out_ready with in_valid low: out_valid goes to 0 and state goes to IDLE. data_out keeps its last value.
  - Simultaneous: out_valid & out_ready & in_valid. in_ready is 1 in this case (in_ready = IDLE | (DONE & out_ready)), so the output handshake and the new input are accepted on the same edge. out_valid goes to 0, state goes to BUSY, and there is no bubble.
  - With out_ready low, in_ready = 0 and new input is stalled.
- BUSY: in_ready = 0. in_valid is ignored, and enc_dec changes do not affect an in-flight state.
- Column math (per column a0..a3, where a0 is the low byte):
  - Encrypt: b0 = 2a0^3a1^a2^a3, rotating cyclically for b1..b3.
  - Decrypt: coefficients {0e,0b,0d,09}, same rotation.
  - Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B). All intermediate widths are 8 bits.
- Reset mid-operation: the in-flight state is discarded, the block returns to IDLE, and out_valid drops immediately. There is no spurious out_valid after reset release.
- The counter wraps only via completion. It is never observed beyond N_STEPS-1.

Decomposition:
- Shared package aes_pkg:
  - STATE_W = 128, COL_W = 32.
  - Functions xtime(byte) and gf_mul(byte, const).
  - Coefficient constants for encrypt and decrypt.
  - FSM state encoding IDLE/BUSY/DONE.
- Sub-module mix_column_word: combinational, 32-bit column in, enc_dec in, 32-bit column out.
  - Instantiated COLS_PER_CYCLE times inside mix_columns_iter.
  - Column selection is a mux driven by the step counter.

Test Plan:
- Single column, COLS_PER_CYCLE=1, enc: data_in = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db}, enc_dec=1. Required: out_valid exactly 4 clocks after accept; data_out = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e}.
- Inverse: feed the previous output with enc_dec=0. data_out must return {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db}.
- Round-trip sweep with COLS_PER_CYCLE = 1, 2 and 4, using random states plus 128'h63cab7040953d051cd60e0e7ba70e18c. Encrypt then decrypt must return the original state. Latency must be 4, 2 and 1 clocks respectively.
- Backpressure: hold out_ready=0 for 10 clocks after out_valid. Required: data_out stable, in_ready=0, a pending in_valid not accepted. Then assert out_ready with in_valid=1. Required: both handshakes on one edge, and the next out_valid N_STEPS clocks later.
- Direction isolation: accept with enc_dec=1, toggle enc_dec during BUSY. The result must match encrypt-only.
- Reset mid-BUSY: pull rst_n low after step 2. Required: out_valid=0, data_out=0, in_ready=1 immediately. After release, a fresh state (the all-zero state) completes normally with data_out = 0.
